// File: rtl/integrator_sat.sv
// Integral-term engine: saturating error accumulator, bit-serial K_i multiply,
// scaled/saturated output with a one-cycle valid pulse toward the PID summer.
module integrator_sat #(
  parameter int E_W   = 6,
  parameter int K_W   = 6,
  parameter int ACC_W = 10,
  parameter int OUT_W = 8,
  parameter int FRAC  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    e_valid,
  output logic                    e_ready,
  input  logic signed [E_W-1:0]   e,
  input  logic        [K_W-1:0]   k_i,
  input  logic                    clr,
  output logic signed [OUT_W-1:0] i_contrib,
  output logic                    out_valid,
  output logic                    acc_sat,
  output logic                    out_sat
);

  localparam int P_W = ACC_W + K_W;
  localparam int C_W = (K_W > 1) ? $clog2(K_W) : 1;

  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [P_W-1:0] OUT_MAX = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] OUT_MIN = {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [P_W-1:0]   mcand_q, mcand_d;
  logic        [K_W-1:0]   mplier_q, mplier_d;
  logic signed [P_W-1:0]   prod_q, prod_d;
  logic        [C_W-1:0]   cnt_q, cnt_d;
  logic signed [OUT_W-1:0] ic_q, ic_d;
  logic                    ov_q, ov_d;
  logic                    asat_q, asat_d;
  logic                    osat_q, osat_d;

  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_new;
  logic signed [P_W-1:0]   prod_sh;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    if (v > ACC_MAX) return ACC_MAX[ACC_W-1:0];
    if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    return v[ACC_W-1:0];
  endfunction

  function automatic logic clip_acc(input logic signed [ACC_W:0] v);
    return (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [P_W-1:0] v);
    if (v > OUT_MAX) return OUT_MAX[OUT_W-1:0];
    if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  function automatic logic clip_out(input logic signed [P_W-1:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction

  // One guard bit so the sum can be range-checked before clipping
  assign acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-E_W){e[E_W-1]}}, e};
  assign acc_new = sat_acc(acc_sum);
  assign prod_sh = prod_q >>> FRAC;

  assign e_ready   = ena && (state_q == IDLE);
  assign i_contrib = ic_q;
  assign out_valid = ov_q;
  assign acc_sat   = asat_q;
  assign out_sat   = osat_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    ic_d     = ic_q;
    ov_d     = 1'b0;
    asat_d   = asat_q;
    osat_d   = osat_q;

    case (state_q)
      IDLE: begin
        if (e_valid) begin
          acc_d    = acc_new;
          asat_d   = clip_acc(acc_sum);
          mcand_d  = clr ? '0 : {{K_W{acc_new[ACC_W-1]}}, acc_new};
          mplier_d = k_i;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = MUL;
        end
      end
      MUL: begin
        // Multiplicand shifts left and multiplier shifts right, so bit 0 is always the current bit
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q <<< 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + C_W'(1);
        if (cnt_q == C_W'(K_W - 1)) state_d = DONE;
      end
      DONE: begin
        ic_d    = sat_out(prod_sh);
        osat_d  = clip_out(prod_sh);
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The in-flight snapshot lives in mcand/mplier, so clearing acc never disturbs it
    if (clr) begin
      acc_d  = '0;
      asat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      ic_q     <= '0;
      ov_q     <= 1'b0;
      asat_q   <= 1'b0;
      osat_q   <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      ic_q     <= ic_d;
      ov_q     <= ov_d;
      asat_q   <= asat_d;
      osat_q   <= osat_d;
    end
  end

endmodule

// File: tb/tb_integrator_sat.sv
// Randomized and directed bench for integrator_sat against a transaction-level
// reference model (accumulate, multiply, scale, clip, countdown to output).
module tb_integrator_sat;

  localparam int E_W   = 6;
  localparam int K_W   = 6;
  localparam int ACC_W = 10;
  localparam int OUT_W = 8;
  localparam int FRAC  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    ena = 1'b1;
  logic                    e_valid = 1'b0;
  logic                    e_ready;
  logic signed [E_W-1:0]   e = '0;
  logic        [K_W-1:0]   k_i = '0;
  logic                    clr = 1'b0;
  logic signed [OUT_W-1:0] i_contrib;
  logic                    out_valid;
  logic                    acc_sat;
  logic                    out_sat;

  integrator_sat #(.E_W(E_W), .K_W(K_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .e_valid(e_valid), .e_ready(e_ready),
    .e(e), .k_i(k_i), .clr(clr), .i_contrib(i_contrib), .out_valid(out_valid),
    .acc_sat(acc_sat), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: integer arithmetic on whole transactions
  int m_acc, m_asat, m_ic, m_osat, m_ov, m_busy, m_pend;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_asat = 0; m_ic = 0; m_osat = 0; m_ov = 0; m_busy = 0; m_pend = 0;
  endtask

  task automatic model_step();
    int s, c, v;
    m_ov = 0;
    if (m_busy == 0) begin
      if (e_valid) begin
        s      = m_acc + int'(e);
        c      = clampi(s, -(1 << (ACC_W-1)), (1 << (ACC_W-1)) - 1);
        m_asat = (c != s);
        m_acc  = c;
        m_pend = (clr ? 0 : c) * int'(k_i);
        m_busy = K_W + 1;
      end
    end else begin
      m_busy--;
      if (m_busy == 0) begin
        v      = m_pend >>> FRAC;
        m_ic   = clampi(v, -(1 << (OUT_W-1)), (1 << (OUT_W-1)) - 1);
        m_osat = (m_ic != v);
        m_ov   = 1;
      end
    end
    if (clr) begin
      m_acc  = 0;
      m_asat = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (ena) model_step();
      #1;
      chk("e_ready", int'(e_ready), int'(ena && (m_busy == 0)));
      chk("out_valid", int'(out_valid), m_ov);
      chk("i_contrib", int'(i_contrib), m_ic);
      chk("acc_sat", int'(acc_sat), m_asat);
      chk("out_sat", int'(out_sat), m_osat);
    end
  end

  // cmode: 0 plain, 1 clr with the sample, 2 clr one cycle into the multiply
  task automatic xfer(input int ev, input int kv, input int cmode, input bit frz,
                      output int res, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!e_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", int'(e_ready), 1);
    e_valid = 1'b1;
    e       = E_W'(ev);
    k_i     = K_W'(kv);
    clr     = (cmode == 1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      e_valid = 1'b0;
      e       = E_W'($urandom);
      clr     = (cmode == 2 && lat == 0);
      ena     = !(frz && lat >= 2 && lat < 5);
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    chk("out_timeout", int'(out_valid), 1);
    res = int'(i_contrib);
    @(negedge clk);
    clr = 1'b0;
    ena = 1'b1;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  int r, l;

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("rst_ic", int'(i_contrib), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", int'(e_ready), 1);

    xfer(5, 3, 0, 0, r, l);
    chk("pos_val", r, 3);
    chk("pos_lat", l, 7);
    chk("pos_osat", int'(out_sat), 0);

    do_clr();
    xfer(-7, 4, 0, 0, r, l);
    chk("neg_val", r, -7);
    xfer(-1, 1, 0, 0, r, l);
    chk("neg_val2", r, -2);

    do_clr();
    for (int i = 0; i < 16; i++) xfer(31, 1, 0, 0, r, l);
    chk("aw_16", r, 124);
    chk("aw_16_sat", int'(acc_sat), 0);
    xfer(31, 1, 0, 0, r, l);
    chk("aw_17", r, 127);
    chk("aw_17_sat", int'(acc_sat), 1);
    xfer(-1, 1, 0, 0, r, l);
    chk("aw_rec", r, 127);
    chk("aw_rec_sat", int'(acc_sat), 0);

    xfer(1, 63, 0, 0, r, l);
    chk("osat_pos", r, 127);
    chk("osat_pos_flag", int'(out_sat), 1);
    do_clr();
    for (int i = 0; i < 16; i++) xfer(-32, 0, 0, 0, r, l);
    chk("k0_val", r, 0);
    chk("k0_osat", int'(out_sat), 0);
    xfer(0, 63, 0, 0, r, l);
    chk("osat_neg", r, -128);
    chk("osat_neg_flag", int'(out_sat), 1);

    // Async reset in the middle of a multiply
    @(negedge clk);
    e_valid = 1'b1; e = E_W'(5); k_i = K_W'(3);
    @(posedge clk);
    @(negedge clk);
    e_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    chk("mrst_ic", int'(i_contrib), 0);
    chk("mrst_ov", int'(out_valid), 0);
    chk("mrst_osat", int'(out_sat), 0);
    chk("mrst_asat", int'(acc_sat), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mrst_ready", int'(e_ready), 1);
    repeat (10) @(negedge clk);
    xfer(5, 3, 0, 0, r, l);
    chk("post_rst_val", r, 3);

    xfer(5, 3, 0, 1, r, l);
    chk("ena_val", r, 7);
    chk("ena_lat", l, 10);

    do_clr();
    for (int i = 0; i < 4; i++) xfer(25, 0, 0, 0, r, l);
    xfer(5, 3, 1, 0, r, l);
    chk("clr_same", r, 0);
    xfer(0, 4, 0, 0, r, l);
    chk("clr_same_acc", r, 0);
    xfer(20, 4, 2, 0, r, l);
    chk("clr_mul", r, 20);
    xfer(0, 4, 0, 0, r, l);
    chk("clr_mul_acc", r, 0);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      e_valid = 1'($urandom_range(0, 1));
      e       = E_W'($urandom);
      k_i     = K_W'($urandom);
      clr     = ($urandom_range(0, 31) == 0);
      ena     = ($urandom_range(0, 7) != 0);
    end
    @(negedge clk);
    e_valid = 1'b0; clr = 1'b0; ena = 1'b1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/integrator_sat.md
Name: integrator_sat

Overview:
Parametrised integral-term engine for the PID datapath. It accumulates signed error samples into a saturating (anti-windup) integral register. The integral is multiplied by the unsigned gain K_i using a sequential shift-add multiplier, one bit per cycle, which keeps area small. The result is scaled, saturated to the output width and presented with a valid/ready handshake toward the PID summer.

Parameters:
E_W, 6, error sample width (signed two's complement)
K_W, 6, gain width (unsigned); also the number of multiply cycles
ACC_W, 10, integral accumulator width (signed); must be >= E_W
OUT_W, 8, output contribution width (signed)
FRAC, 2, arithmetic right shift applied to the product (fixed-point gain scaling)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
ena  in  1  global enable; low freezes all state
e_valid  in  1  error sample valid
e_ready  out  1  block can accept a sample
e  in  E_W  signed error sample
k_i  in  K_W  unsigned integral gain, sampled on acceptance
clr  in  1  synchronous clear of the integral accumulator
i_contrib  out  OUT_W  signed integral contribution (registered)
out_valid  out  1  one-cycle pulse: i_contrib updated
acc_sat  out  1  last accumulation clipped at a rail
out_sat  out  1  last output clipped at a rail

Behaviour:
- Reset (rst_n low, async): acc=0, i_contrib=0, out_valid=0, acc_sat=0, out_sat=0, state=IDLE, counters=0. e_ready=1 in the first cycle after release when ena=1.
- ena=0: every register holds, including state, acc, multiplier, counter and out_valid. e_ready is forced 0. ena gates all updates except reset.
- States:
  - IDLE: e_ready=ena. On e_valid&e_ready:
    - acc <= clamp(acc+e), computed at ACC_W+1 bits.
    - Snapshot the new acc as the multiplicand; latch k_i as the multiplier.
    - Clear the partial product; count=0; go to MUL.
  - MUL: each enabled cycle, if multiplier bit[count]=1, add (multiplicand sign-extended to ACC_W+K_W) << count to the product. count++. After the K_W-th step go to DONE.
  - DONE (one cycle): i_contrib <= clamp(product >>> FRAC) to OUT_W; out_sat set accordingly; out_valid=1 for this one cycle; go to IDLE.
- Latency: accept at edge T0. i_contrib and out_valid update at edge T0+K_W+1 (plus any ena-low cycles). Throughput is one sample per K_W+2 cycles; e_ready=0 outside IDLE.
- Clamp limits:
  - acc: max 2^(ACC_W-1)-1, min -2^(ACC_W-1).
  - output: max 2^(OUT_W-1)-1, min -2^(OUT_W-1).
  - acc_sat/out_sat are updated on each accumulation/output event and hold otherwise.
- Anti-windup: the accumulator never exceeds its rails, so recovery begins on the next opposite-sign sample with no backlog.
- >>> is arithmetic (floor toward -inf). k_i=0 gives product 0.
- clr (when ena=1):
  - acc <= 0 and acc_sat <= 0.
  - clr wins over a same-cycle accumulation; that sample is still accepted and multiplied with multiplicand 0.
  - In MUL/DONE, clr does not disturb the in-flight snapshot.
- The multiplicand snapshot isolates the multiplier from later acc changes.
- Async reset mid-MUL aborts the operation; no out_valid is produced.

Test Plan:
Reset: assert rst_n low asynchronously mid-MUL -> all outputs 0 immediately, no out_valid; after release e_ready=1 -> next sample processed normally.
Positive: acc=0, e=5, k_i=3 -> acc=5, product 15, i_contrib=3 (15>>>2), out_valid pulse exactly 7 edges after acceptance, out_sat=0.
Negative: acc=0, e=-7, k_i=4 -> acc=-7, product -28, i_contrib=-7 (8'hF9); e=-1, k_i=1 next -> acc=-8, product -8, i_contrib=-2.
Anti-windup: e=31, k_i=1 repeated 17 times -> acc 496 after 16 samples, 511 after the 17th with acc_sat=1; then e=-1 -> acc=510, acc_sat=0.
Output saturation: acc=511, k_i=63 -> product 32193, 32193>>>2=8048 -> i_contrib=127, out_sat=1; mirrored with acc=-512 -> i_contrib=-128.
ena/clr: drop ena for 3 cycles during MUL -> out_valid delayed exactly 3 cycles with unchanged value; clr with e_valid in the same cycle (acc=100, e=5) -> acc=0, i_contrib=0; clr during MUL -> in-flight result unaffected, acc=0 afterwards.
